// File: rtl/flopenrd_core.sv
// -----------------------------------------------------------------------------
// flopenrd_core
//   Enabled register / enabled delay line with asynchronous active-low reset.
//   Default build is a single 8-bit stage. DEPTH > 1 gives a cascade of
//   stages that all advance together on enabled clock edges.
//
// Parameters:
//   WIDTH     - data width in bits (>= 1)
//   DEPTH     - number of cascaded enabled stages (>= 1); q is the last one
//   RESET_VAL - value loaded into every stage while reset is low
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous reset, active low (0 = in reset)
//   en     in   1      stage-advance enable, sampled on rising clk
//   d      in   WIDTH  data in
//   q      out  WIDTH  data out (last stage, registered)
//   q_par  out  1      even parity of q (only when FLOPENRD_PARITY_EN is defined)
//
// Optional feature macro: FLOPENRD_PARITY_EN
//   When defined, adds q_par, registered alongside the last stage so that it
//   is always coherent with q. Its reset value is the XOR reduction of
//   RESET_VAL.
//
// Reset deassertion is not synchronised here; the integrator provides a
// synchronised release.
// -----------------------------------------------------------------------------
module flopenrd_core #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
`ifdef FLOPENRD_PARITY_EN
    output logic             q_par,
`endif
    output logic [WIDTH-1:0] q
);

    // stage[0] takes d; stage[DEPTH-1] drives q.
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VAL;
            end
        end else if (en) begin
            stage[0] <= d;
            // Whole line shifts as one; there is no per-stage enable.
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

`ifdef FLOPENRD_PARITY_EN
    // Value that the last stage will load on the next enabled edge. Parity is
    // computed from it so q_par updates on exactly the same edge as q.
    logic [WIDTH-1:0] last_in;

    if (DEPTH == 1) begin : g_last_in_d
        assign last_in = d;
    end else begin : g_last_in_stage
        assign last_in = stage[DEPTH-2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_par <= ^RESET_VAL;
        end else if (en) begin
            q_par <= ^last_in;
        end
    end
`endif

endmodule

// File: tb/tb_flopenrd_core.sv
// -----------------------------------------------------------------------------
// tb_flopenrd_core
//   Directed self-checking bench for flopenrd_core. Two instances share one
//   clock: dut_a uses the default configuration (DEPTH=1, RESET_VAL=0) and
//   dut_b is a 3-deep delay line with RESET_VAL=8'hA5.
//   Expected values are hand-computed constants; the dut_b sequence is held
//   in an expected queue and popped once per enabled/disabled edge.
// -----------------------------------------------------------------------------
module tb_flopenrd_core;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, en_a;
    logic [7:0] d_a, q_a;
    logic       reset_b, en_b;
    logic [7:0] d_b, q_b;
`ifdef FLOPENRD_PARITY_EN
    logic       q_par_a, q_par_b;
`endif

    flopenrd_core dut_a (
        .clk   (clk),
        .reset (reset_a),
        .en    (en_a),
        .d     (d_a),
`ifdef FLOPENRD_PARITY_EN
        .q_par (q_par_a),
`endif
        .q     (q_a)
    );

    flopenrd_core #(
        .WIDTH     (8),
        .DEPTH     (3),
        .RESET_VAL (8'hA5)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .en    (en_b),
        .d     (d_b),
`ifdef FLOPENRD_PARITY_EN
        .q_par (q_par_b),
`endif
        .q     (q_b)
    );

    // ---------------- scoreboard ----------------
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // en must be known whenever reset is released.
    always @(posedge clk) begin
        if ((reset_a === 1'b1 && $isunknown(en_a)) || (reset_b === 1'b1 && $isunknown(en_b))) begin
            failures++;
            $display("FAIL en_unknown: got X expected 0/1 at %0t", $time);
        end
    end

    // ---------------- driver tasks ----------------
    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic en, input logic [7:0] d);
        en_a = en;
        d_a  = d;
    endtask

    task automatic drive_b(input logic en, input logic [7:0] d);
        en_b = en;
        d_b  = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] e;

        reset_a = 1'b1;
        reset_b = 1'b1;
        drive_a(1'b0, 8'h33);
        drive_b(1'b0, 8'h33);
        #2;
        reset_a = 1'b0;
        reset_b = 1'b0;
        #1;
        // Reset takes effect immediately, before any clock edge.
        check("a_rst_imm", q_a, 8'h00);
        check("b_rst_imm", q_b, 8'hA5);
`ifdef FLOPENRD_PARITY_EN
        check("a_par_rst", {7'b0, q_par_a}, 8'h00);
        check("b_par_rst", {7'b0, q_par_b}, 8'h00);
`endif

        // Inputs ignored while reset is low.
        for (int i = 0; i < 2; i++) begin
            drive_a(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            tick();
            check("a_rst_hold", q_a, 8'h00);
        end

        // ---- dut_a: enabled capture ----
        reset_a = 1'b1;
        drive_a(1'b1, 8'hFF);
        tick();
        check("a_cap_ff", q_a, 8'hFF);
        drive_a(1'b1, 8'h5A);
        tick();
        check("a_cap_5a", q_a, 8'h5A);
`ifdef FLOPENRD_PARITY_EN
        check("a_par_5a", {7'b0, q_par_a}, 8'h00);
`endif
        drive_a(1'b1, 8'hFF);
        tick();
        check("a_cap_ff2", q_a, 8'hFF);

        // ---- dut_a: hold ----
        drive_a(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("a_hold", q_a, 8'hFF);
        end

        // ---- dut_a: async reset between edges ----
        drive_a(1'b1, 8'hFF);
        #2;
        reset_a = 1'b0;
        #1;
        check("a_async_rst", q_a, 8'h00);

        // Reset dominates en at a rising edge.
        tick();
        check("a_rst_prio", q_a, 8'h00);

        // Re-release.
        reset_a = 1'b1;
        drive_a(1'b1, 8'hFF);
        tick();
        check("a_rerelease", q_a, 8'hFF);

        // ---- dut_b: 3-deep line, one disabled edge in the middle ----
        reset_b = 1'b1;
        // q after each edge: en 01 -> A5, en 02 -> A5, hold -> A5,
        // en 03 -> 01, en 04 -> 02, en 05 -> 03.
        exp_q = '{8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03};

        drive_b(1'b1, 8'h01); tick();
        e = exp_q.pop_front(); check("b_edge1", q_b, e);
        drive_b(1'b1, 8'h02); tick();
        e = exp_q.pop_front(); check("b_edge2", q_b, e);
        drive_b(1'b0, 8'h77); tick();
        e = exp_q.pop_front(); check("b_disabled", q_b, e);
        drive_b(1'b1, 8'h03); tick();
        e = exp_q.pop_front(); check("b_edge3", q_b, e);
`ifdef FLOPENRD_PARITY_EN
        check("b_par_01", {7'b0, q_par_b}, 8'h01);
`endif
        drive_b(1'b1, 8'h04); tick();
        e = exp_q.pop_front(); check("b_edge4", q_b, e);
        drive_b(1'b1, 8'h05); tick();
        e = exp_q.pop_front(); check("b_edge5", q_b, e);
`ifdef FLOPENRD_PARITY_EN
        check("b_par_03", {7'b0, q_par_b}, 8'h00);
`endif

        // Mid-flight reset discards the pipeline contents.
        drive_b(1'b1, 8'h06);
        #2;
        reset_b = 1'b0;
        #1;
        check("b_async_rst", q_b, 8'hA5);
        tick();
        check("b_rst_prio", q_b, 8'hA5);

        // ---- final report ----
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
